keypad_scanner: RTL
===================

Name: keypad_scanner

Overview:
- Input-side counterpart of the multiplexed 7-segment display driver: scans a 4x4 hex keypad matrix one row at a time and reports debounced key presses.
- Drives one keypad row low at a time (rotating one-hot-low, same scheme as the display anode rotation) and samples the active-low column lines.
- Delivers a 4-bit key code with a one-cycle valid strobe. The calculator core uses this strobe in place of its switch-and-button digit entry.

Parameters:
- SCAN_DIV, 16'h4000: clock cycles each row stays driven (dwell); must be >= 4.
- DEB_CNT, 3: consecutive identical samples required to accept a press or a release; 1..15.

Ports:
- uclk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- row_n  out  4  keypad row drive, active low; exactly one bit low at all times after reset.
- col_n  in  4  keypad column sense, active low, externally pulled up; asynchronous to uclk.
- key  out  4  last accepted key code = {row_idx[1:0], col_idx[1:0]}; index = bit position of the low bit.
- key_valid  out  1  one-cycle pulse when a new key is accepted.
- key_held  out  1  high while the accepted key remains pressed.
- error  out  1  sticky flag: a multi-key pattern was seen; cleared by the next key_valid.

Behaviour:
- Reset (async, rst_n=0) sets:
  - row_n=4'b1110, key=0, key_valid=0, key_held=0, error=0
  - state=SCAN, dwell counter=0, debounce counter=0, synchronizer flops=4'hF
- col_n passes through a 2-flop synchronizer (col_s). All decisions use col_s only.
- Dwell counter:
  - Counts 0..SCAN_DIV-1 continuously in every state, then wraps to 0.
  - A "sample" is taken on the cycle where the counter equals SCAN_DIV-1.
- Sample classes:
  - NONE: col_s==4'hF.
  - ONE: exactly one col_s bit low.
  - MULTI: two or more bits low.
- SCAN state:
  - At each sample, rotate row_n left (1110 -> 1101 -> 1011 -> 0111 -> 1110) unless the sample is ONE.
  - ONE: latch row_idx and col_idx as the candidate, set the debounce counter to 1, hold row_n, go to DEBOUNCE.
  - MULTI: set error=1 and keep rotating.
- DEBOUNCE state (row_n held):
  - At each sample, if ONE with the same column as the candidate, increment the debounce counter.
  - Otherwise (NONE, MULTI, or a different column): counter=0, return to SCAN, and resume rotating at the next sample. MULTI also sets error=1.
  - When the counter reaches DEB_CNT: on the following clock, key=candidate code, key_valid=1 for exactly one cycle, key_held=1, error=0, go to HELD.
  - If DEB_CNT=1, acceptance follows the first ONE sample directly.
- HELD state (row_n held):
  - At each sample, count consecutive NONE samples; any non-NONE sample resets this count.
  - No further key_valid is produced while in HELD (no auto-repeat).
  - When the count reaches DEB_CNT: key_held=0 on the next clock, go to SCAN, and resume rotation from the held row at the next sample.
- key holds its value until the next acceptance.
- Latency: a clean press first seen at sample k produces key_valid one clock after sample k+DEB_CNT-1.
- MULTI while in HELD is ignored (still held); error is not set.
- rst_n asserted mid-DEBOUNCE or mid-HELD: immediate return to the reset state. No key_valid is emitted.
- All outputs are registered; no combinational path from col_n to any output.

Test Plan:
All scenarios use SCAN_DIV=8, DEB_CNT=3.
- Reset/rotation: release rst_n, col_n=4'hF.
  -> row_n=1110, then 1101 after 8 cycles, 1011 after 16, 0111 after 24, 1110 after 32. key_valid, key_held, error stay 0.
- Clean press: drive col_n=1101 whenever row_n=1011, steady for 100 cycles.
  -> key_valid high for exactly one cycle, key=4'h9, key_held=1, row_n frozen at 1011, no second pulse.
- Release: after the clean press, set col_n=4'hF.
  -> key_held falls one cycle after the 3rd consecutive empty sample (about 24 cycles); row_n resumes rotating at the next sample; key stays 4'h9.
- Bounce: press row0/col3 (col_n=0111 while row_n=1110) for 2 samples, then release.
  -> no key_valid, key unchanged, scanning resumes.
- Multi-key: col_n=0101 on row1.
  -> error=1, no key_valid, rotation continues. A subsequent clean press of row3/col0 gives key_valid with key=4'hC, and error clears on the same cycle.
- Async reset during DEBOUNCE (after 2 matching samples): pull rst_n low mid-cycle.
  -> all outputs take reset values immediately. After release, no key_valid appears until a fresh 3-sample qualification.

Source files
------------

// File: rtl/keypad_if.sv
// Keypad matrix and key-event signals shared by the scanner and its consumer.
// master = scanner side, slave = keypad/consumer side.
interface keypad_if;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key;
  logic       key_valid;
  logic       key_held;
  logic       error;

  modport master (
    output row_n, key, key_valid, key_held, error,
    input  col_n
  );

  modport slave (
    input  row_n, key, key_valid, key_held, error,
    output col_n
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner: rotates one low row, samples synchronized columns once per
// dwell period, debounces press and release, and emits a one-cycle key_valid strobe.
module keypad_scanner #(
  parameter int SCAN_DIV = 16'h4000,
  parameter int DEB_CNT  = 3
) (
  input logic      uclk,
  input logic      rst_n,
  keypad_if.master bus
);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

  localparam logic [15:0] DWELL_LAST = 16'(SCAN_DIV - 1);
  localparam logic [3:0]  DEB_LIM    = 4'(DEB_CNT);

  logic [3:0]  col_m, col_s;
  logic [15:0] dwell;
  logic        sample;

  state_t      state, state_next;
  logic [3:0]  row_q, row_next;
  logic [3:0]  cand_q, cand_next;
  logic [3:0]  deb_q, deb_next;
  logic [3:0]  key_q, key_next;
  logic        valid_q, valid_next;
  logic        held_q, held_next;
  logic        err_q, err_next;
  logic        accept;

  logic [3:0]  col_low;
  logic        col_none, col_one;
  logic [1:0]  col_idx, row_idx;

  // col_n is asynchronous to uclk; nothing downstream looks at it before col_s.
  always_ff @(posedge uclk or negedge rst_n) begin
    if (!rst_n) begin
      col_m <= 4'hF;
      col_s <= 4'hF;
    end else begin
      col_m <= bus.col_n;
      col_s <= col_m;
    end
  end

  always_ff @(posedge uclk or negedge rst_n) begin
    if (!rst_n)      dwell <= 16'd0;
    else if (sample) dwell <= 16'd0;
    else             dwell <= dwell + 16'd1;
  end

  assign sample   = (dwell == DWELL_LAST);
  assign col_low  = ~col_s;
  assign col_none = (col_low == 4'd0);
  assign col_one  = !col_none && ((col_low & (col_low - 4'd1)) == 4'd0);

  always_comb begin
    col_idx = 2'd0;
    row_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (col_low[i]) col_idx = 2'(i);
      if (!row_q[i])  row_idx = 2'(i);
    end
  end

  // NOTE: every variable gets its hold value before the case so no path infers a latch.
  always_comb begin
    state_next = state;
    row_next   = row_q;
    cand_next  = cand_q;
    deb_next   = deb_q;
    key_next   = key_q;
    valid_next = 1'b0;
    held_next  = held_q;
    err_next   = err_q;
    accept     = 1'b0;

    if (sample) begin
      case (state)
        SCAN: begin
          if (col_one) begin
            cand_next  = {row_idx, col_idx};
            deb_next   = 4'd1;
            state_next = DEBOUNCE;
            accept     = (DEB_LIM == 4'd1);
          end else begin
            row_next = {row_q[2:0], row_q[3]};
            if (!col_none) err_next = 1'b1;
          end
        end
        DEBOUNCE: begin
          if (col_one && (col_idx == cand_q[1:0])) begin
            deb_next = deb_q + 4'd1;
            accept   = ((deb_q + 4'd1) == DEB_LIM);
          end else begin
            // Row stays put on this sample; rotation resumes at the next one.
            deb_next   = 4'd0;
            state_next = SCAN;
            if (!col_none) err_next = 1'b1;
          end
        end
        HELD: begin
          if (col_none) begin
            deb_next = deb_q + 4'd1;
            if ((deb_q + 4'd1) == DEB_LIM) begin
              deb_next   = 4'd0;
              held_next  = 1'b0;
              state_next = SCAN;
            end
          end else begin
            deb_next = 4'd0;
          end
        end
        default: state_next = SCAN;
      endcase
    end

    if (accept) begin
      key_next   = cand_next;
      valid_next = 1'b1;
      held_next  = 1'b1;
      err_next   = 1'b0;
      deb_next   = 4'd0;
      state_next = HELD;
    end
  end

  // NOTE: state registers use non-blocking assignment so all flops update together.
  always_ff @(posedge uclk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= SCAN;
      row_q   <= 4'b1110;
      cand_q  <= 4'd0;
      deb_q   <= 4'd0;
      key_q   <= 4'd0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_next;
      row_q   <= row_next;
      cand_q  <= cand_next;
      deb_q   <= deb_next;
      key_q   <= key_next;
      valid_q <= valid_next;
      held_q  <= held_next;
      err_q   <= err_next;
    end
  end

  assign bus.row_n     = row_q;
  assign bus.key       = key_q;
  assign bus.key_valid = valid_q;
  assign bus.key_held  = held_q;
  assign bus.error     = err_q;

endmodule
